// File: rtl/spart_tx_sched.sv
// spart_tx_sched
//   Shares one SPART transmitter between two byte requesters. A round-robin
//   arbiter accepts bytes into a small FIFO. A drain FSM then issues one-cycle
//   write strobes to the transmitter and follows its tbr flag until each
//   frame is done. This block is the only driver of iorw/ioaddr/databus.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   req[1:0]       level request per requester, held until granted
//   data0, data1   byte offered by requester 0 / 1
//   gnt[1:0]       one-hot pulse: that requester's byte is accepted this cycle
//   tbr            transmitter ready (1 = idle, 0 = shifting a frame)
//   iorw, ioaddr   transmitter bus control (iorw=0, ioaddr=00 is a TX write)
//   databus        byte presented to the transmitter
//   fifo_count     entries currently queued
//   busy           FIFO non-empty or a frame still in flight
module spart_tx_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [7:0]    data0,
  input  logic [7:0]    data1,
  output logic [1:0]    gnt,
  input  logic          tbr,
  output logic          iorw,
  output logic [1:0]    ioaddr,
  output logic [7:0]    databus,
  output logic [AW:0]   fifo_count,
  output logic          busy
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [AW:0] FULL        = DEPTH[AW:0];
  localparam logic [3:0]  TMO_LAST    = 4'd14;  // 15th WAIT_BUSY cycle

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rr_q, rr_d;        // index of the last granted requester
  logic [1:0]    state_q, state_d;
  logic [3:0]    tmo_q, tmo_d;
  logic [7:0]    databus_q, databus_d;

  logic          pop;
  logic          push;
  logic          can_push;
  logic [7:0]    push_data;

  // Arbitration and FIFO bookkeeping
  always_comb begin
    pop      = (state_q == S_ISSUE);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    can_push = (count_q != FULL) || pop;
    gnt      = 2'b00;
    if (can_push) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    push      = |gnt;
    push_data = gnt[1] ? data1 : data0;

    rr_d = rr_q;
    if (gnt[1])      rr_d = 1'b1;
    else if (gnt[0]) rr_d = 1'b0;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Drain FSM
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    databus_d = databus_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && tbr) begin
          state_d   = S_ISSUE;
          // Load the head byte now so it is stable for the whole strobe
          // cycle and then simply holds afterwards.
          databus_d = mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = 4'd0;
      end
      S_WAIT_BUSY: begin
        if (!tbr) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Transmitter never acknowledged; treat the byte as sent.
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_WAIT_DONE: begin
        if (tbr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_q      <= 1'b1;
      state_q   <= S_IDLE;
      tmo_q     <= 4'd0;
      databus_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      databus_q <= databus_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign iorw       = (state_q != S_ISSUE);
  assign ioaddr     = (state_q == S_ISSUE) ? 2'b00 : 2'b01;
  assign databus    = databus_q;
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_spart_tx_sched.sv
module tb_spart_tx_sched;

  localparam int FRAME = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       tbr;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus;
  logic [2:0] fifo_count;
  logic       busy;

  logic tbr_m;
  logic stall;
  logic drop_next;
  assign tbr = tbr_m & ~stall;

  spart_tx_sched #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .req({req1, req0}), .data0(data0), .data1(data1),
    .gnt(gnt), .tbr(tbr), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_strobes = 0;
  int last_strobe_cyc = 0;
  int strobe_gap = 0;

  byte unsigned q0[$];
  byte unsigned q1[$];
  logic [1:0]   exp_gnt[$];
  byte unsigned exp_tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester 0: offers the head of q0 until it is granted.
  initial begin
    req0 = 1'b0; data0 = 8'h00;
    forever begin
      @(negedge clk);
      if (req0 && gnt[0] && !rst) void'(q0.pop_front());
      @(posedge clk); #1;
      if (q0.size() > 0) begin req0 = 1'b1; data0 = q0[0]; end
      else req0 = 1'b0;
    end
  end

  // Requester 1
  initial begin
    req1 = 1'b0; data1 = 8'h00;
    forever begin
      @(negedge clk);
      if (req1 && gnt[1] && !rst) void'(q1.pop_front());
      @(posedge clk); #1;
      if (q1.size() > 0) begin req1 = 1'b1; data1 = q1[0]; end
      else req1 = 1'b0;
    end
  end

  // Transmitter model: drops tbr the cycle after a strobe for FRAME cycles.
  initial begin
    tbr_m = 1'b1;
    drop_next = 1'b0;
    forever begin
      @(negedge clk);
      if (iorw == 1'b0 && ioaddr == 2'b00) begin
        if (drop_next) drop_next = 1'b0;
        else begin
          @(posedge clk); #1 tbr_m = 1'b0;
          repeat (FRAME) @(posedge clk);
          #1 tbr_m = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: compares grants and transmitted bytes against queues.
  initial begin
    logic prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt != 2'b00) begin
          if (exp_gnt.size() == 0) begin
            n_checks++;
            $display("FAIL gnt_unexpected: got %b with nothing expected (cycle %0d)", gnt, cyc);
          end else chk("gnt_order", {30'd0, gnt}, {30'd0, exp_gnt.pop_front()});
        end
        if (iorw == 1'b0) begin
          chk("strobe_addr", {30'd0, ioaddr}, 32'd0);
          chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
          if (exp_tx.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected: got strobe of %0h with nothing expected (cycle %0d)", databus, cyc);
          end else chk("tx_byte", {24'd0, databus}, {24'd0, exp_tx.pop_front()});
          n_strobes++;
          strobe_gap = cyc - last_strobe_cyc;
          last_strobe_cyc = cyc;
        end
      end
      prev_strobe = !rst && (iorw == 1'b0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(busy == 1'b0 && tbr == 1'b1 && q0.size() == 0 &&
                            q1.size() == 0 && exp_tx.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && iorw != 1'b0) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, (n < budget)}, 32'd1);
  endtask

  initial begin
    int s0;
    int n;
    rst = 1'b1;
    stall = 1'b0;

    // Reset then idle
    do_reset();
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_iorw", {31'd0, iorw}, 32'd1);
    chk("rst_ioaddr", {30'd0, ioaddr}, 32'd1);
    chk("rst_databus", {24'd0, databus}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    s0 = n_strobes;
    repeat (100) @(negedge clk);
    chk("idle_no_strobe", n_strobes - s0, 32'd0);

    // Single byte
    exp_gnt.push_back(2'b01);
    exp_tx.push_back(8'hA5);
    q0.push_back(8'hA5);
    n = 0;
    while (n < 20 && gnt != 2'b01) begin @(negedge clk); n++; end
    chk("single_gnt_seen", {31'd0, (n < 20)}, 32'd1);
    @(negedge clk);
    chk("single_count", {29'd0, fifo_count}, 32'd1);
    wait_drain("single_drain", 100);
    chk("single_busy", {31'd0, busy}, 32'd0);
    chk("single_databus_hold", {24'd0, databus}, 32'hA5);

    // Round-robin from a fresh reset: requester 0 first
    do_reset();
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10);
      exp_tx.push_back(8'h11);  exp_tx.push_back(8'h22);
      q0.push_back(8'h11);      q1.push_back(8'h22);
    end
    wait_drain("rr_drain", 200);

    // Full FIFO while the transmitter is held busy
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      q0.push_back(8'(i));
      exp_gnt.push_back(2'b01);
      exp_tx.push_back(8'(i));
    end
    repeat (12) @(negedge clk);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_gnt_blocked", {30'd0, gnt}, 32'd0);
    chk("full_req_held", {31'd0, req0}, 32'd1);
    chk("full_no_strobe", {31'd0, iorw}, 32'd1);
    stall = 1'b0;
    wait_strobe("full_release_strobe", 10);
    chk("full_gnt_on_pop", {30'd0, gnt}, 32'd1);
    chk("full_count_on_pop", {29'd0, fifo_count}, 32'd4);
    wait_drain("full_drain", 300);

    // Timeout: first strobe is never acknowledged
    drop_next = 1'b1;
    s0 = n_strobes;
    q0.push_back(8'h33); q0.push_back(8'h44);
    exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b01);
    exp_tx.push_back(8'h33);  exp_tx.push_back(8'h44);
    wait_strobe("tmo_first_strobe", 20);
    wait_strobe("tmo_second_strobe", 40);
    chk("tmo_gap", strobe_gap, 32'd17);
    wait_drain("tmo_drain", 100);
    chk("tmo_strobe_total", n_strobes - s0, 32'd2);

    // Reset mid-frame with two bytes queued
    q0.push_back(8'h55); q0.push_back(8'h66); q0.push_back(8'h77);
    for (int i = 0; i < 3; i++) exp_gnt.push_back(2'b01);
    exp_tx.push_back(8'h55);
    n = 0;
    while (n < 30 && !(tbr == 1'b0 && fifo_count == 3'd2)) begin @(negedge clk); n++; end
    chk("midrst_reached", {31'd0, (n < 30)}, 32'd1);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("midrst_count", {29'd0, fifo_count}, 32'd0);
    chk("midrst_iorw", {31'd0, iorw}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    s0 = n_strobes;
    repeat (50) @(negedge clk);
    chk("midrst_no_strobe", n_strobes - s0, 32'd0);
    chk("exp_tx_empty", exp_tx.size(), 32'd0);
    chk("exp_gnt_empty", exp_gnt.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spart_tx_sched.md
Name: spart_tx_sched

Overview:
- Sequences and shares the SPART serial transmitter between two byte requesters (e.g. processor port and loopback/debug port).
- Round-robin arbitration loads accepted bytes into a shared FIFO.
- A drain FSM issues one-cycle write strobes on the transmitter's bus, then tracks its tbr busy/ready flag until each frame completes.
- Sits between the requesters and the transmitter; is the only driver of the transmitter's iorw/ioaddr/databus.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
AW, 2, log2(DEPTH); count width is AW+1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  2  requester i has a byte on data_i (level, held until gnt)
data0  in  8  requester 0 byte
data1  in  8  requester 1 byte
gnt  out  2  one-hot one-cycle pulse: byte from requester i accepted this cycle
tbr  in  1  transmitter ready (1 = idle, 0 = shifting)
iorw  out  1  to transmitter; 0 = write
ioaddr  out  2  to transmitter; 2'b00 = TX data
databus  out  8  byte to transmitter
fifo_count  out  AW+1  entries held
busy  out  1  1 when FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - FIFO empty; rd/wr pointers 0; rr pointer = 1, so requester 0 wins first.
  - FSM to IDLE.
  - Outputs: gnt=0, iorw=1, ioaddr=2'b01, databus=8'h00, fifo_count=0, busy=0.
  - Reset mid-frame abandons the frame. Output defaults guarantee no write strobe on the cycle after reset.
- Arbitration (combinational grant, registered into FIFO):
  - Grant only when the FIFO is not full, or when a pop occurs in the same cycle.
  - One requester asserting: it is granted.
  - Both asserting: grant the requester != last granted; rr pointer updates to the granted index.
  - At most one gnt bit per cycle.
  - On gnt, the selected data is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - Full with no pop: gnt=0; requesters hold.
- FIFO:
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Pop only in the ISSUE state.
- Drain FSM (states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE):
  - Outside ISSUE: iorw=1, ioaddr=2'b01, databus holds the last value.
  - IDLE:
    - FIFO non-empty and tbr=1: go to ISSUE.
    - tbr=0 (transmitter busy from another cause): stay in IDLE.
  - ISSUE (exactly one cycle):
    - iorw=0, ioaddr=2'b00, databus=fifo[rd_ptr].
    - Pop; go to WAIT_BUSY.
  - WAIT_BUSY:
    - Wait for tbr=0, which the transmitter asserts the cycle after the strobe; then go to WAIT_DONE.
    - 4-bit timeout: if tbr stays 1 for 15 cycles, return to IDLE. The byte is treated as sent and is not re-issued.
  - WAIT_DONE: wait for tbr=1, then go to IDLE.
- Frame spacing: minimum one IDLE cycle between frames. Issue-to-issue spacing is therefore the frame duration plus 2 cycles.
- Ordering:
  - Bytes are transmitted in grant order.
  - A requester's bytes are never reordered.

Test Plan:
- Reset then idle:
  - rst high 2 cycles, req=0 -> gnt=0, iorw=1, ioaddr=01, fifo_count=0, busy=0.
  - No strobe for 100 cycles.
- Single byte:
  - req0=1, data0=8'hA5 for one grant -> gnt=2'b01 once, fifo_count 0->1.
  - ISSUE strobe: iorw=0, ioaddr=00, databus=A5 for exactly 1 cycle.
  - Then tbr low; after tbr returns high, busy=0.
- Round-robin:
  - req=2'b11 held, data0=8'h11, data1=8'h22 -> grants alternate 01,10,01,10.
  - Transmit order 11,22,11,22.
- Full FIFO:
  - Stall tbr=0 externally; req0 streaming 8'h01..8'h05 -> 4 grants, fifo_count=4, then gnt=0.
  - Release tbr -> 5th byte granted the same cycle as the first pop; final order 01..05.
- Timeout: bench holds tbr=1 after the strobe -> FSM returns to IDLE after 15 cycles; next byte is issued; no duplicate of the first byte.
- Reset mid-frame:
  - rst asserted in WAIT_DONE with 2 bytes queued -> fifo_count=0, iorw=1.
  - After rst deasserts, no strobe until a new req.
